// File: rtl/div_pkg.sv
// Shared types and constants for the signed divide controller.
package div_pkg;

  localparam int WA = 32;
  localparam int WB = 16;

  localparam logic [WA-1:0] DZ_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    FIX,
    DONE,
    DRAIN
  } state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation, wrapping mod 2^W.
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/div_sign_ctrl.sv
// Sign handling, divide-by-zero and flush control wrapped around an unsigned
// restoring divider core; presents a held, back-pressurable signed result.
module div_sign_ctrl
  import div_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_signed,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  input  logic          flush,
  output logic [WA-1:0] core_a,
  output logic [WB-1:0] core_b,
  output logic          core_start,
  input  logic [WA-1:0] core_q,
  input  logic [WB-1:0] core_r,
  input  logic          core_busy,
  input  logic          core_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] out_q,
  output logic [WB-1:0] out_r,
  output logic          out_dz,
  output logic          busy
);

  state_t        r_state;
  state_t        w_state_next;

  logic          w_accept;
  logic          w_b_zero;
  logic          w_neg_a;
  logic          w_neg_b;
  logic [WA-1:0] w_mag_a;
  logic [WB-1:0] w_mag_b;
  logic [WA-1:0] w_fix_q;
  logic [WB-1:0] w_fix_r;

  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_dz;
  logic [WA-1:0] r_core_a;
  logic [WB-1:0] r_core_b;
  logic [WA-1:0] r_q;
  logic [WB-1:0] r_r;
  logic [WA-1:0] r_out_q;
  logic [WB-1:0] r_out_r;
  logic          r_out_dz;

  assign w_accept = in_valid & in_ready;
  assign w_b_zero = (in_b == '0);
  assign w_neg_a  = in_signed & in_a[WA-1];
  assign w_neg_b  = in_signed & in_b[WB-1];

  cond_negate #(.W(WA)) u_mag_a (.x(in_a), .neg(w_neg_a),  .y(w_mag_a));
  cond_negate #(.W(WB)) u_mag_b (.x(in_b), .neg(w_neg_b),  .y(w_mag_b));
  cond_negate #(.W(WA)) u_fix_q (.x(r_q),  .neg(r_sign_q), .y(w_fix_q));
  cond_negate #(.W(WB)) u_fix_r (.x(r_r),  .neg(r_sign_r), .y(w_fix_r));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_b_zero ? FIX : START;
      START:   w_state_next = flush ? IDLE : WAIT;
      WAIT: begin
        // A flush racing the completion pulse has nothing left to drain.
        if (flush)           w_state_next = core_ready ? IDLE : DRAIN;
        else if (core_ready) w_state_next = FIX;
      end
      FIX:     w_state_next = flush ? IDLE : DONE;
      DONE:    if (flush || out_ready) w_state_next = IDLE;
      DRAIN:   if (core_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = ~flush & ~core_busy;
        busy     = 1'b0;
      end
      START:   core_start = ~flush;
      DONE:    out_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_core_a <= '0;
      r_core_b <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_out_q  <= '0;
      r_out_r  <= '0;
      r_out_dz <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_a <= w_mag_a;
        r_core_b <= w_mag_b;
        if (w_b_zero) begin
          // Zero divisor bypasses the core; signs cleared so FIX passes values through.
          r_sign_q <= 1'b0;
          r_sign_r <= 1'b0;
          r_q      <= DZ_QUOT;
          r_r      <= in_a[WB-1:0];
          r_dz     <= 1'b1;
        end else begin
          r_sign_q <= in_signed & (in_a[WA-1] ^ in_b[WB-1]);
          r_sign_r <= w_neg_a;
          r_dz     <= 1'b0;
        end
      end
      if ((r_state == WAIT) && core_ready && !flush) begin
        r_q <= core_q;
        r_r <= core_r;
      end
      if ((r_state == FIX) && !flush) begin
        r_out_q  <= w_fix_q;
        r_out_r  <= w_fix_r;
        r_out_dz <= r_dz;
      end
    end
  end

  assign core_a = r_core_a;
  assign core_b = r_core_b;
  assign out_q  = r_out_q;
  assign out_r  = r_out_r;
  assign out_dz = r_out_dz;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Self-checking bench: behavioural 32-cycle divider core plus arithmetic reference.
module tb_div_sign_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid, in_ready, in_signed, flush;
  logic [31:0] in_a, core_a, core_q, out_q;
  logic [15:0] in_b, core_b, core_r, out_r;
  logic        core_start, core_busy, core_ready;
  logic        out_valid, out_ready, out_dz, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int core_cnt;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [15:0] b;
  } vec_t;

  div_sign_ctrl dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .flush(flush),
    .core_a(core_a), .core_b(core_b), .core_start(core_start),
    .core_q(core_q), .core_r(core_r), .core_busy(core_busy), .core_ready(core_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .busy(busy)
  );

  always #5 clock = ~clock;

  // Core model: start sampled at E1, ready pulse raised at E33, seen by the controller at E34.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      core_cnt   <= 0;
      core_busy  <= 1'b0;
      core_ready <= 1'b0;
      core_q     <= '0;
      core_r     <= '0;
    end else begin
      core_ready <= 1'b0;
      if (core_start && !core_busy) begin
        core_busy <= 1'b1;
        core_cnt  <= 32;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy  <= 1'b0;
          core_ready <= 1'b1;
          core_q     <= (core_b != 0) ? core_a / {16'h0, core_b} : '1;
          core_r     <= (core_b != 0) ? 16'(core_a % {16'h0, core_b}) : '0;
        end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(posedge clock) if (core_start) n_start++;

  // Truncating signed/unsigned division straight from the arithmetic definition.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r, output logic dz);
    longint sa, sb;
    if (b == 16'h0) begin
      q = '1; r = a[15:0]; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else   begin sa = longint'({32'h0, a}); sb = longint'({48'h0, b}); end
      q = 32'(sa / sb);
      r = 16'(sa % sb);
    end
  endfunction

  task automatic issue(input logic s, input logic [31:0] a, input logic [15:0] b);
    int w = 0;
    while (in_ready !== 1'b1 && w < 200) begin @(posedge clock); #1; w++; end
    if (w >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
    end
    in_valid = 1'b1; in_signed = s; in_a = a; in_b = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({in_ready, core_start, out_valid, out_dz, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {in_ready,core_start,out_valid,out_dz,busy}=%b required 10000",
               {in_ready, core_start, out_valid, out_dz, busy});
    end
    n_checks++;
    if ({core_a, core_b} !== 48'h0) begin
      n_fail++; $display("FAIL reset_core_ops: core_a=%h core_b=%h required 0", core_a, core_b);
    end
    n_checks++;
    if ({out_q, out_r} !== 48'h0) begin
      n_fail++; $display("FAIL reset_out: out_q=%h out_r=%h required 0", out_q, out_r);
    end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_arith;
    vec_t vq[$];
    vec_t v;
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    int          lat, st0, exp_lat;
    vq.push_back('{1'b1, 32'd100, 16'd7});
    vq.push_back('{1'b1, 32'hFFFF_FF9C, 16'd7});
    vq.push_back('{1'b1, 32'd100, 16'hFFF9});
    vq.push_back('{1'b0, 32'hFFFF_FFFF, 16'hFFFF});
    vq.push_back('{1'b1, 32'h8000_0000, 16'hFFFF});
    for (int i = 0; i < 24; i++) begin
      v.s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v.a = 32'h8000_0000;
        1:       v.a = 32'h7FFF_FFFF;
        2:       v.a = $urandom_range(0, 1000);
        default: v.a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       v.b = 16'hFFFF;
        1:       v.b = 16'h8000;
        2:       v.b = 16'($urandom_range(1, 50));
        3:       v.b = 16'($urandom);
        default: v.b = 16'h0;
      endcase
      vq.push_back(v);
    end
    foreach (vq[k]) begin
      v = vq[k];
      ref_div(v.s, v.a, v.b, eq, er, edz);
      exp_lat = (v.b == 16'h0) ? 1 : 35;
      st0 = n_start;
      issue(v.s, v.a, v.b);
      wait_valid(lat);
      $display("txn s=%0d a=%h b=%h -> q=%h r=%h dz=%0d lat=%0d", v.s, v.a, v.b, out_q, out_r, out_dz, lat);
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++; $display("FAIL arith_latency[%0d]: got %0d required %0d", k, lat, exp_lat);
      end
      n_checks++;
      if ({out_q, out_r, out_dz} !== {eq, er, edz}) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                 k, out_q, out_r, out_dz, eq, er, edz);
      end
      n_checks++;
      if ((n_start - st0) !== ((v.b == 16'h0) ? 0 : 1)) begin
        n_fail++; $display("FAIL arith_starts[%0d]: got %0d core_start pulses", k, n_start - st0);
      end
      consume();
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] av[2];
    int lat, st0;
    av[0] = 32'h1234_5678;
    av[1] = 32'h8765_4321;
    for (int i = 0; i < 2; i++) begin
      st0 = n_start;
      issue(1'(i), av[i], 16'h0);
      wait_valid(lat);
      $display("txn dz s=%0d a=%h -> q=%h r=%h dz=%0d lat=%0d", i, av[i], out_q, out_r, out_dz, lat);
      // Visible after the edge following accept; the consumer first samples it at E2.
      n_checks++;
      if (lat !== 1) begin
        n_fail++; $display("FAIL dz_latency[%0d]: got %0d required 1", i, lat);
      end
      n_checks++;
      if ({out_q, out_r, out_dz} !== {32'hFFFF_FFFF, av[i][15:0], 1'b1}) begin
        n_fail++;
        $display("FAIL dz_result[%0d]: q=%h r=%h dz=%b required q=ffffffff r=%h dz=1",
                 i, out_q, out_r, out_dz, av[i][15:0]);
      end
      n_checks++;
      if (n_start !== st0) begin
        n_fail++; $display("FAIL dz_no_start[%0d]: got %0d pulses required 0", i, n_start - st0);
      end
      consume();
    end
  endtask

  task automatic test_flush;
    int  lat, st0;
    bit  seen = 0;
    st0 = n_start;
    issue(1'b0, 32'd1000, 16'd3);
    repeat (11) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (core_ready === 1'b1) seen = 1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_drain[%0d]: in_ready=%b out_valid=%b required 0 0", c, in_ready, out_valid);
      end
      if (!seen) begin @(posedge clock); #1; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL flush_core_ready: core_ready=0 within 60 cycles, required 1");
    end
    @(posedge clock); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_release: in_ready=%b required 1", in_ready);
    end
    $display("txn flushed a=1000 b=3 in WAIT");
    issue(1'b0, 32'd9, 16'd2);
    wait_valid(lat);
    $display("txn s=0 a=9 b=2 -> q=%h r=%h dz=%0d lat=%0d", out_q, out_r, out_dz, lat);
    n_checks++;
    if ({lat, out_q, out_r, out_dz} !== {32'd35, 32'd4, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_next: lat=%0d q=%h r=%h dz=%b required 35 4 1 0", lat, out_q, out_r, out_dz);
    end
    n_checks++;
    if (n_start - st0 !== 2) begin
      n_fail++; $display("FAIL flush_starts: got %0d required 2", n_start - st0);
    end
    consume();
  endtask

  task automatic test_backpressure;
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    int lat;
    ref_div(1'b1, 32'hFFFF_FFCE, 16'd6, eq, er, edz);
    issue(1'b1, 32'hFFFF_FFCE, 16'd6);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({out_valid, in_ready, out_q, out_r, out_dz} !== {1'b1, 1'b0, eq, er, edz}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: valid=%b in_ready=%b q=%h r=%h dz=%b required 1 0 %h %h %b",
                 c, out_valid, in_ready, out_q, out_r, out_dz, eq, er, edz);
      end
    end
    $display("txn s=1 a=-50 b=6 held 5 cycles -> q=%h r=%h", out_q, out_r);
    consume();
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b1, 32'hFFFF_FC18, 16'd10);
    wait_valid(lat);
    consume();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    issue(1'b0, 32'd123457, 16'd100);
    wait_valid(lat);
    $display("txn b2b s=0 a=123457 b=100 -> q=%h r=%h lat=%0d", out_q, out_r, lat);
    n_checks++;
    if ({lat, out_q, out_r} !== {32'd35, 32'd1234, 16'd57}) begin
      n_fail++; $display("FAIL b2b_result: lat=%0d q=%h r=%h required 35 4d2 39", lat, out_q, out_r);
    end
    consume();
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(1'b0, 32'd77, 16'd5);
    repeat (6) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, core_start, out_valid, out_dz, busy, core_a, core_b, out_q, out_r} !== {5'b10000, 96'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b start=%b valid=%b dz=%b busy=%b core_a=%h core_b=%h q=%h r=%h",
               in_ready, core_start, out_valid, out_dz, busy, core_a, core_b, out_q, out_r);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_mid_ready: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    issue(1'b0, 32'd77, 16'd5);
    wait_valid(lat);
    $display("txn after reset a=77 b=5 -> q=%h r=%h lat=%0d", out_q, out_r, lat);
    n_checks++;
    if ({lat, out_q, out_r} !== {32'd35, 32'd15, 16'd2}) begin
      n_fail++; $display("FAIL reset_mid_next: lat=%0d q=%h r=%h required 35 f 2", lat, out_q, out_r);
    end
    consume();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_arith();
    test_div_zero();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
